// File: rtl/spi_drv_pkg.sv
// rtl/spi_drv_pkg.sv - shared state codes, constants and helpers for the SPI frame sequencer
package spi_drv_pkg;

   localparam int TX_COUNT_W = 5;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD   = 3'd1;
   localparam state_t ST_SEND   = 3'd2;
   localparam state_t ST_SETTLE = 3'd3;
   localparam state_t ST_WAIT   = 3'd4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((r < 31) && ((1 << r) < value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// rtl/spi_word_fifo.sv - show-ahead command word FIFO, power-of-two depth
module spi_word_fifo
   import spi_drv_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_push,
   input  logic [WIDTH-1:0]              i_data,
   input  logic                          i_pop,
   output logic [WIDTH-1:0]              o_head,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [clog2(DEPTH+1)-1:0]     o_level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - buffers command words and serialises them MSB-first as byte handoffs
// Optional rx readback assembly: define SPI_FRAME_RX_CAPTURE_EN.
module spi_frame_sequencer
   import spi_drv_pkg::*;
#(
   parameter int FRAME_BYTES = 3,
   parameter int WORD_W      = 8 * FRAME_BYTES,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                              i_FPGA_clk,
   input  logic                              i_FPGA_rst,
   input  logic                              i_word_valid,
   input  logic [WORD_W-1:0]                 i_word,
   output logic                              o_word_ready,
   output logic [clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level,
   output logic [TX_COUNT_W-1:0]             o_tx_count,
   output logic [7:0]                        o_tx_byte,
   output logic                              o_tx_dv,
   input  logic                              i_tx_ready,
   input  logic                              i_rx_dv,
   input  logic [7:0]                        i_rx_byte,
   output logic [WORD_W-1:0]                 o_rx_word,
   output logic                              o_rx_valid,
   output logic                              o_busy,
   output logic [CNT_W-1:0]                  o_frames_done
);

   localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

   state_t            r_state;
   logic [WORD_W-1:0] r_sreg;
   logic [1:0]        r_byte_idx;
   logic [7:0]        r_tx_byte;
   logic [CNT_W-1:0]  r_frames_done;
   logic [WORD_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_tx_dv;
   logic [7:0]        w_top_byte;

   assign o_word_ready  = !w_full;
   assign w_push        = i_word_valid && !w_full;
   assign w_pop         = (r_state == ST_LOAD);
   assign w_top_byte    = r_sreg[WORD_W-1 -: 8];
   assign w_tx_dv       = (r_state == ST_SEND) && i_tx_ready;
   assign o_tx_dv       = w_tx_dv;
   // Present the live byte with its strobe, then hold it until the next one.
   assign o_tx_byte     = w_tx_dv ? w_top_byte : r_tx_byte;
   assign o_tx_count    = TX_COUNT_W'(FRAME_BYTES);
   assign o_busy        = (r_state != ST_IDLE) || !w_empty;
   assign o_frames_done = r_frames_done;

   spi_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_FPGA_clk),
      .i_rst_n (i_FPGA_rst),
      .i_push  (w_push),
      .i_data  (i_word),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );

   always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
      if (!i_FPGA_rst) begin
         r_state       <= ST_IDLE;
         r_sreg        <= '0;
         r_byte_idx    <= '0;
         r_tx_byte     <= '0;
         r_frames_done <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_sreg     <= w_head;
               r_byte_idx <= '0;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               if (i_tx_ready) begin
                  r_tx_byte <= w_top_byte;
                  r_sreg    <= r_sreg << 8;
                  r_state   <= ST_SETTLE;
               end
            end
            // The engine may still show ready here from the previous byte.
            ST_SETTLE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (i_tx_ready) begin
                  if (r_byte_idx == LAST_IDX) begin
                     r_frames_done <= r_frames_done + CNT_W'(1);
                     r_state       <= w_empty ? ST_IDLE : ST_LOAD;
                  end else begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_state    <= ST_SEND;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SPI_FRAME_RX_CAPTURE_EN
   logic [WORD_W-1:0] r_rx_sreg;
   logic [WORD_W-1:0] r_rx_word;
   logic [WORD_W-1:0] w_rx_next;
   logic [1:0]        r_rx_cnt;
   logic              r_rx_valid;

   assign w_rx_next  = (r_rx_sreg << 8) | WORD_W'(i_rx_byte);
   assign o_rx_word  = r_rx_word;
   assign o_rx_valid = r_rx_valid;

   // Starting a new frame realigns the byte count with the transmit side.
   always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
      if (!i_FPGA_rst) begin
         r_rx_sreg  <= '0;
         r_rx_word  <= '0;
         r_rx_cnt   <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (r_state == ST_LOAD) begin
            r_rx_cnt <= '0;
         end else if (i_rx_dv) begin
            r_rx_sreg <= w_rx_next;
            if (r_rx_cnt == LAST_IDX) begin
               r_rx_word  <= w_rx_next;
               r_rx_valid <= 1'b1;
               r_rx_cnt   <= '0;
            end else begin
               r_rx_cnt <= r_rx_cnt + 2'd1;
            end
         end
      end
   end
`else
   logic w_unused_rx;

   assign w_unused_rx = ^{i_rx_dv, i_rx_byte};
   assign o_rx_word   = '0;
   assign o_rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - self-checking bench for spi_frame_sequencer
module tb_spi_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        word_valid = 1'b0;
   logic [23:0] in_word = '0;
   logic        word_ready;
   logic [2:0]  fifo_level;
   logic [4:0]  tx_count;
   logic [7:0]  tx_byte;
   logic        tx_dv;
   logic        tx_ready = 1'b1;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = '0;
   logic [23:0] rx_word;
   logic        rx_valid;
   logic        busy;
   logic [15:0] frames_done;

   logic        w2_valid = 1'b0;
   logic [7:0]  w2_word = 8'h5A;
   logic        w2_ready;
   logic [2:0]  w2_level;
   logic [4:0]  w2_tx_count;
   logic [7:0]  w2_tx_byte;
   logic        w2_tx_dv;
   logic [7:0]  w2_rx_word;
   logic        w2_rx_valid;
   logic        w2_busy;
   logic [3:0]  w2_frames;

   always #5 clk = ~clk;

   spi_frame_sequencer dut (
      .i_FPGA_clk    (clk),
      .i_FPGA_rst    (rst_n),
      .i_word_valid  (word_valid),
      .i_word        (in_word),
      .o_word_ready  (word_ready),
      .o_fifo_level  (fifo_level),
      .o_tx_count    (tx_count),
      .o_tx_byte     (tx_byte),
      .o_tx_dv       (tx_dv),
      .i_tx_ready    (tx_ready),
      .i_rx_dv       (rx_dv),
      .i_rx_byte     (rx_byte),
      .o_rx_word     (rx_word),
      .o_rx_valid    (rx_valid),
      .o_busy        (busy),
      .o_frames_done (frames_done)
   );

   spi_frame_sequencer #(
      .FRAME_BYTES (1),
      .WORD_W      (8),
      .FIFO_DEPTH  (4),
      .CNT_W       (4)
   ) dut2 (
      .i_FPGA_clk    (clk),
      .i_FPGA_rst    (rst_n),
      .i_word_valid  (w2_valid),
      .i_word        (w2_word),
      .o_word_ready  (w2_ready),
      .o_fifo_level  (w2_level),
      .o_tx_count    (w2_tx_count),
      .o_tx_byte     (w2_tx_byte),
      .o_tx_dv       (w2_tx_dv),
      .i_tx_ready    (1'b1),
      .i_rx_dv       (1'b0),
      .i_rx_byte     (8'h00),
      .o_rx_word     (w2_rx_word),
      .o_rx_valid    (w2_rx_valid),
      .o_busy        (w2_busy),
      .o_frames_done (w2_frames)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];
   logic prev_dv = 1'b0;

   typedef struct {
      logic [23:0] word;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;
   vec_t vecs[6];

`ifdef SPI_FRAME_RX_CAPTURE_EN
   localparam logic [23:0] RX_EXP    = 24'h112233;
   localparam int          RX_PULSES = 1;
`else
   localparam logic [23:0] RX_EXP    = 24'h000000;
   localparam int          RX_PULSES = 0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every byte strobe must match the next expected byte.
   always @(negedge clk) begin
      if (tx_dv) begin
         check("dv_gap", {31'd0, prev_dv}, 32'd0);
         check("scoreboard_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      end
      prev_dv = tx_dv;
   end

   task automatic push_word(input logic [23:0] w, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2);
      int t;
      t = 0;
      word_valid = 1'b1;
      in_word    = w;
      while (!word_ready && t < 200) begin
         tick();
         t++;
      end
      check("push_accepted", {31'd0, t < 200}, 32'd1);
      if (t < 200) begin
         exp_q.push_back(e0);
         exp_q.push_back(e1);
         exp_q.push_back(e2);
      end
      tick();
      word_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 2000) begin
         tick();
         t++;
      end
      check("idle_reached", {31'd0, t < 2000}, 32'd1);
      check("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   task automatic wait_dv_count(input int n, input string name);
      int seen;
      int t;
      seen = 0;
      t = 0;
      while (t < 500) begin
         if (tx_dv) seen++;
         if (seen == n) break;
         tick();
         t++;
      end
      check(name, seen, n);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_tx_dv"},    {31'd0, tx_dv},      32'd0);
      check({tag, "_tx_byte"},  {24'd0, tx_byte},    32'd0);
      check({tag, "_rx_valid"}, {31'd0, rx_valid},   32'd0);
      check({tag, "_rx_word"},  {8'd0, rx_word},     32'd0);
      check({tag, "_frames"},   {16'd0, frames_done}, 32'd0);
      check({tag, "_busy"},     {31'd0, busy},       32'd0);
      check({tag, "_level"},    {29'd0, fifo_level}, 32'd0);
      check({tag, "_ready"},    {31'd0, word_ready}, 32'd1);
      check({tag, "_tx_count"}, {27'd0, tx_count},   32'd3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int stall_dv;
      int pulses;
      int t;
      logic [7:0] rx_seq [3];

      vecs[0] = '{24'h123456, 8'h12, 8'h34, 8'h56};
      vecs[1] = '{24'hFF0080, 8'hFF, 8'h00, 8'h80};
      vecs[2] = '{24'h00FF01, 8'h00, 8'hFF, 8'h01};
      vecs[3] = '{24'h8001C3, 8'h80, 8'h01, 8'hC3};
      vecs[4] = '{24'h7E5AA5, 8'h7E, 8'h5A, 8'hA5};
      vecs[5] = '{24'hC0FFEE, 8'hC0, 8'hFF, 8'hEE};

      repeat (3) tick();
      check_reset_state("in_reset");
      rst_n = 1'b1;
      tick();
      check_reset_state("after_reset");

      // Single frame, first-byte latency and byte hold.
      push_word(24'hA53C0F, 8'hA5, 8'h3C, 8'h0F);
      check("t1_level", {29'd0, fifo_level}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      check("t1_load_no_dv", {31'd0, tx_dv}, 32'd0);
      tick();
      check("t1_first_dv", {31'd0, tx_dv}, 32'd1);
      wait_idle();
      check("t1_frames", {16'd0, frames_done}, 32'd1);
      check("t1_busy_after", {31'd0, busy}, 32'd0);
      check("t1_byte_held", {24'd0, tx_byte}, 32'h0F);

      // Fill the FIFO while the engine is stalled; the sixth word must wait.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(vecs[i].word, vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check("t2_level_full", {29'd0, fifo_level}, 32'd4);
      check("t2_ready_low", {31'd0, word_ready}, 32'd0);
      word_valid = 1'b1;
      in_word    = vecs[5].word;
      repeat (5) tick();
      check("t2_held_ready", {31'd0, word_ready}, 32'd0);
      check("t2_held_level", {29'd0, fifo_level}, 32'd4);
      check("t2_no_frames", {16'd0, frames_done}, 32'd1);
      tx_ready = 1'b1;
      push_word(vecs[5].word, vecs[5].b0, vecs[5].b1, vecs[5].b2);
      wait_idle();
      check("t2_frames", {16'd0, frames_done}, 32'd7);

      // Engine stalls for 7 cycles after the second byte.
      push_word(24'hDEAD01, 8'hDE, 8'hAD, 8'h01);
      wait_dv_count(2, "t3_second_byte");
      tick();
      tx_ready = 1'b0;
      stall_dv = 0;
      repeat (7) begin
         tick();
         if (tx_dv) stall_dv++;
      end
      check("t3_stall_no_dv", stall_dv, 32'd0);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
      tx_ready = 1'b1;
      tick();
      check("t3_resume_dv", {31'd0, tx_dv}, 32'd1);
      wait_idle();
      check("t3_frames", {16'd0, frames_done}, 32'd8);

      // Reset in the middle of a frame with two words queued.
      push_word(24'h111111, 8'h11, 8'h11, 8'h11);
      push_word(24'h222222, 8'h22, 8'h22, 8'h22);
      push_word(24'h333333, 8'h33, 8'h33, 8'h33);
      wait_dv_count(2, "t4_second_byte");
      check("t4_queued", {29'd0, fifo_level}, 32'd2);
      tick();
      exp_q.delete();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_state("midframe_reset");
      push_word(24'h010203, 8'h01, 8'h02, 8'h03);
      wait_idle();
      check("t4_frames", {16'd0, frames_done}, 32'd1);

      // Readback assembly.
      rx_seq[0] = 8'h11;
      rx_seq[1] = 8'h22;
      rx_seq[2] = 8'h33;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         rx_byte = rx_seq[i];
         rx_dv   = 1'b1;
         tick();
         if (rx_valid) pulses++;
         rx_dv = 1'b0;
         tick();
         if (rx_valid) pulses++;
      end
      repeat (3) begin
         tick();
         if (rx_valid) pulses++;
      end
      check("t5_rx_pulses", pulses, RX_PULSES);
      check("t5_rx_word", {8'd0, rx_word}, {8'd0, RX_EXP});

      // Frame counter wrap on a 4-bit, 1-byte instance.
      check("t6_tx_count", {27'd0, w2_tx_count}, 32'd1);
      w2_valid = 1'b1;
      t = 0;
      while (w2_frames != 4'hF && t < 400) begin
         tick();
         t++;
      end
      check("t6_reach_max", {28'd0, w2_frames}, 32'hF);
      t = 0;
      while (w2_frames == 4'hF && t < 40) begin
         tick();
         t++;
      end
      check("t6_wrap_zero", {28'd0, w2_frames}, 32'd0);
      w2_valid = 1'b0;
      t = 0;
      while (w2_busy && t < 200) begin
         tick();
         t++;
      end
      check("t6_idle", {31'd0, w2_busy}, 32'd0);
      check("t6_level", {29'd0, w2_level}, 32'd0);
      check("t6_ready", {31'd0, w2_ready}, 32'd1);
      check("t6_tx_dv", {31'd0, w2_tx_dv}, 32'd0);
      check("t6_byte_held", {24'd0, w2_tx_byte}, 32'h5A);
      check("t6_rx_valid", {31'd0, w2_rx_valid}, 32'd0);
      check("t6_rx_word", {24'd0, w2_rx_word}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
